mux8_rr_arbiter: RTL and testbench
==================================

// Module: mux8_rr_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for the 8:1 16-bit bus mux (Mux8X1_16Bit).
//  Shares the mux between 8 requesters: picks a winner, drives the mux select/enable,
//  captures the selected 16-bit word and presents it downstream on a valid/ready handshake.
//  Sits between the pipeline-stage sources (mux inputs I0..I7) and a single 16-bit consumer.
// PARAMETERS
//  WIDTH     16  data width of mux output / captured word
//  MAX_HOLD  4   max consecutive grants to one locked requester (>=1; 1 = lock ignored)
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous active-low reset
//  req        in   8      req[i]=1: requester i has a word on mux input Ii; held until ack[i]
//  lock       in   8      lock[i]=1 with req[i]: requester i asks to keep the grant (burst)
//  mux_s      out  3      mux select, registered; drives Mux8X1_16Bit.s
//  mux_e      out  1      mux enable, registered; drives Mux8X1_16Bit.E
//  mux_dout   in   WIDTH  mux output (Mux8X1_16Bit.out), combinational from mux_s
//  ack        out  8      one-hot 1-cycle pulse: word from requester i captured
//  out_valid  out  1      out_data holds a captured word
//  out_ready  in   1      consumer accepts out_data when out_valid & out_ready
//  out_data   out  WIDTH  captured word, stable while out_valid=1
//  out_src    out  3      index of requester that supplied out_data
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, ptr=0, hold_cnt=0, mux_s=0, mux_e=0, ack=0,
//   out_valid=0, out_data=0, out_src=0. In-flight word is dropped, no ack issued.
//  Arbitration (ARB): winner = first i with req[i]=1 scanning ptr, ptr+1, ... mod 8.
//   Lock override: if last winner w has req[w]&lock[w] and hold_cnt<MAX_HOLD-1, winner=w,
//   hold_cnt++. Otherwise RR winner, hold_cnt<=0. On every grant ptr<=(winner+1) mod 8.
//  FSM:
//   IDLE:   if |req: ARB; mux_s<=winner, mux_e<=1 -> SELECT. Else stay; mux_e=0.
//   SELECT: out_data<=mux_dout, out_src<=mux_s, ack[mux_s]<=1 (next cycle, 1 cycle),
//           out_valid<=1, mux_e<=0 -> VALID. Capture happens even if req dropped.
//   VALID:  hold out_data/out_src. If out_ready: out_valid<=0; if |req (ack'd requester
//           excluded this cycle since ack is high) ARB, mux_e<=1 -> SELECT; else -> IDLE.
//           If !out_ready: stay, no arbitration, mux_e=0.
//  Latency: req rise in IDLE -> mux_e=1 next edge -> capture+out_valid one edge later (2 clk).
//  Throughput: one word per 2 clk with out_ready tied high.
//  mux_s holds last value when mux_e=0 (no glitching of select).
//  ack excludes its requester from ARB in the same cycle (requester drops req after ack).
//  out_valid never deasserts without handshake except by reset.
//  All req=0: stays IDLE, outputs static. ptr wraps 7->0.
// TESTING
//  1 reset_n=0 mid-SELECT with req=8'h08 -> all outputs zero next sample, no ack[3], IDLE.
//  2 req=8'h08, mux_dout=16'hBEEF, out_ready=1 -> mux_s=3,mux_e=1 @+1; out_valid=1,
//    out_data=BEEF, out_src=3, ack=8'h08 @+2.
//  3 req=8'hFF held (drop each bit on its ack), ptr=0 -> grant order 0,1,...,7, one every 2 clk.
//  4 out_ready=0 for 5 clk with out_valid=1, req=8'h21 -> out_data stable, no ack, mux_e=0;
//    on out_ready=1 next grant = RR winner.
//  5 MAX_HOLD=4, req[2]&lock[2] held, req[5]=1 -> four consecutive grants to 2, then 5.
//  6 req=8'h80 then 8'h01 -> grants 7 then 0 (ptr wrap).

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for an 8:1 bus mux: grants one requester, drives the
// mux select/enable, captures the selected word and offers it on a valid/ready handshake.
module mux8_rr_arbiter #(
   parameter int WIDTH    = 16,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       req,
   input  logic [7:0]       lock,
   output logic [2:0]       mux_s,
   output logic             mux_e,
   input  logic [WIDTH-1:0] mux_dout,
   output logic [7:0]       ack,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       out_src
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      VALID  = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

   state_t     state;
   logic [2:0] ptr;
   logic [7:0] hold_cnt;

   logic [7:0] eligible;
   logic [2:0] idx;
   logic [2:0] rr_win;
   logic       rr_found;
   logic       lock_ok;
   logic [2:0] win;
   logic       win_lock;
   logic       can_grant;

   // Winner selection: lock override on the last winner (mux_s), else first eligible from ptr.
   // The requester being acked this cycle is excluded from the round-robin scan.
   always_comb begin
      eligible = req & ~ack;
      idx      = 3'd0;
      rr_win   = ptr;
      rr_found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         idx = ptr + 3'(k);
         if (!rr_found && eligible[idx]) begin
            rr_found = 1'b1;
            rr_win   = idx;
         end else begin
            rr_found = rr_found;
         end
      end
      lock_ok = req[mux_s] & lock[mux_s] & (hold_cnt < HOLD_LIM);
      if (lock_ok) begin
         win      = mux_s;
         win_lock = 1'b1;
      end else begin
         win      = rr_win;
         win_lock = 1'b0;
      end
      can_grant = lock_ok | rr_found;
   end

   // Sequencer FSM with registered mux controls, ack pulse and output word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ptr       <= 3'd0;
         hold_cnt  <= 8'd0;
         mux_s     <= 3'd0;
         mux_e     <= 1'b0;
         ack       <= 8'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 3'd0;
      end else begin
         ack <= 8'd0;
         case (state)
            IDLE: begin
               if (can_grant) begin
                  mux_s    <= win;
                  mux_e    <= 1'b1;
                  ptr      <= win + 3'd1;
                  hold_cnt <= win_lock ? hold_cnt + 8'd1 : 8'd0;
                  state    <= SELECT;
               end else begin
                  mux_e <= 1'b0;
               end
            end
            SELECT: begin
               out_data  <= mux_dout;
               out_src   <= mux_s;
               ack       <= 8'd1 << mux_s;
               out_valid <= 1'b1;
               mux_e     <= 1'b0;
               state     <= VALID;
            end
            VALID: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (can_grant) begin
                     mux_s    <= win;
                     mux_e    <= 1'b1;
                     ptr      <= win + 3'd1;
                     hold_cnt <= win_lock ? hold_cnt + 8'd1 : 8'd0;
                     state    <= SELECT;
                  end else begin
                     mux_e <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  mux_e <= 1'b0;
               end
            end
            default: begin
               mux_e <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized + directed bench for mux8_rr_arbiter against a transaction-level reference model.
module tb_mux8_rr_arbiter;

   localparam int WIDTH = 16;
   localparam int MH    = 4;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [7:0]       req = 8'd0;
   logic [7:0]       lock = 8'd0;
   logic [2:0]       mux_s;
   logic             mux_e;
   logic [WIDTH-1:0] mux_dout;
   logic [7:0]       ack;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [2:0]       out_src;

   logic [WIDTH-1:0] word [8];
   logic [7:0]       keep = 8'd0;

   int checks = 0;
   int errors = 0;

   // reference model: 0 = waiting for requests, 1 = word being selected, 2 = word offered
   int        m_phase, m_ptr, m_hold, m_last;
   bit [7:0]  m_ack;
   bit        m_e, m_v;
   bit [2:0]  m_s;
   bit [15:0] m_data;
   int        m_src;
   int        grants[$];

   mux8_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MH)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .lock(lock),
      .mux_s(mux_s), .mux_e(mux_e), .mux_dout(mux_dout), .ack(ack),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
   );

   assign mux_dout = word[mux_s];

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_ptr = 0; m_hold = 0; m_last = 0;
      m_ack = 8'd0; m_e = 1'b0; m_v = 1'b0; m_s = 3'd0; m_data = 16'd0; m_src = 0;
   endtask

   function automatic int pick(input bit [7:0] r, input bit [7:0] l, input bit [7:0] a,
                               output bit locked);
      locked = 1'b0;
      if (r[m_last] && l[m_last] && m_hold < MH - 1) begin
         locked = 1'b1;
         return m_last;
      end
      for (int k = 0; k < 8; k++) begin
         if (r[(m_ptr + k) % 8] && !a[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
      end
      return -1;
   endfunction

   function automatic bit try_grant(input bit [7:0] a_pre);
      bit lk;
      int w;
      w = pick(req, lock, a_pre, lk);
      if (w < 0) return 1'b0;
      m_s = 3'(w); m_e = 1'b1; m_last = w;
      m_ptr = (w + 1) % 8;
      m_hold = lk ? m_hold + 1 : 0;
      m_phase = 1;
      grants.push_back(w);
      return 1'b1;
   endfunction

   task automatic model_edge();
      bit [7:0] a_pre;
      a_pre = m_ack;
      m_ack = 8'd0;
      case (m_phase)
         0: if (!try_grant(a_pre)) m_e = 1'b0;
         1: begin
            m_data = word[m_s]; m_src = m_s; m_ack = 8'd1 << m_s;
            m_v = 1'b1; m_e = 1'b0; m_phase = 2;
         end
         default: begin
            if (out_ready) begin
               m_v = 1'b0;
               if (!try_grant(a_pre)) begin
                  m_e = 1'b0; m_phase = 0;
               end
            end else begin
               m_e = 1'b0;
            end
         end
      endcase
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, ".mux_e"}, mux_e, m_e);
      check_eq({tag, ".mux_s"}, mux_s, m_s);
      check_eq({tag, ".ack"}, ack, m_ack);
      check_eq({tag, ".out_valid"}, out_valid, m_v);
      check_eq({tag, ".out_data"}, out_data, m_data);
      check_eq({tag, ".out_src"}, out_src, m_src);
   endtask

   // one clock: edge, model update, compare on the falling edge, requesters drop on ack
   task automatic step(input string tag);
      @(posedge clk);
      @(negedge clk);
      model_edge();
      compare_all(tag);
      req = req & ~(ack & ~keep);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) word[i] = 16'($urandom);
      model_reset();
      repeat (2) @(negedge clk);
      compare_all("reset");
      reset_n = 1'b1;

      // single request: select then capture two edges later
      word[3] = 16'hBEEF; out_ready = 1'b1; req = 8'h08;
      step("t2a");
      check_eq("t2_sel", {mux_e, mux_s}, {1'b1, 3'd3});
      step("t2b");
      check_eq("t2_data", out_data, 16'hBEEF);
      check_eq("t2_ack", ack, 8'h08);
      check_eq("t2_src", out_src, 3'd3);
      repeat (3) step("t2c");

      // pointer wrap: 7 then 0
      grants.delete();
      req = 8'h80; repeat (4) step("t6a");
      req = 8'h01; repeat (4) step("t6b");
      check_eq("t6_n", grants.size(), 2);
      if (grants.size() == 2) begin
         check_eq("t6_g0", grants[0], 7);
         check_eq("t6_g1", grants[1], 0);
      end
      req = 8'h80; repeat (4) step("t3pre");

      // all requesting from ptr=0: strict order, one grant every 2 clocks
      grants.delete();
      req = 8'hFF; repeat (18) step("t3");
      check_eq("t3_n", grants.size(), 8);
      for (int i = 0; i < 8 && i < grants.size(); i++) check_eq("t3_order", grants[i], i);

      // backpressure with a word held for 5 clocks
      out_ready = 1'b0; req = 8'h21;
      repeat (7) step("t4hold");
      check_eq("t4_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      repeat (6) step("t4go");

      // locked burst: four grants to 2, then 5
      grants.delete();
      keep = 8'h04; lock = 8'h04; req = 8'h24;
      repeat (12) step("t5");
      check_eq("t5_n", grants.size() >= 5, 1'b1);
      if (grants.size() >= 5) begin
         for (int i = 0; i < 4; i++) check_eq("t5_lock", grants[i], 2);
         check_eq("t5_next", grants[4], 5);
      end
      keep = 8'h00; lock = 8'h00; req = 8'h00;
      repeat (4) step("t5drain");

      // reset asserted while a word is being selected
      req = 8'h08;
      step("t1a");
      check_eq("t1_sel", mux_e, 1'b1);
      #2 reset_n = 1'b0;
      #1 model_reset();
      req = 8'h00;
      compare_all("t1rst");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) step("t1post");

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 8; i++) begin
            if (!req[i] && $urandom_range(0, 3) == 0) begin
               word[i] = 16'($urandom);
               req[i]  = 1'b1;
            end
         end
         lock = 8'($urandom) & 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
